// File: rtl/rgb_pwm_test_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rgb_pwm_test_top                                           |
// | Description : IO test image top. Drives CHANNELS RGB LEDs with PWM       |
// |               brightness from a shared animation frame, plus one         |
// |               seven-segment digit. Modes: 00 direct, 01 auto-step,       |
// |               10 triangle breathe, 11 hold.                              |
// | Ports       : clk, async_rst (async, active-high)                        |
// |               clk_en           - advance enable for all internal state   |
// |               count_lower      - direct frame value (modes 00/10)        |
// |               invert_led_state - toggles the invert flag                 |
// |               mode             - operating mode                          |
// |               frame_out        - current frame register                  |
// |               step_strobe      - one-clk pulse on each auto-step         |
// |               digit            - registered animation segment pattern    |
// |               rgb_pwm          - PWM-gated colour, channel c at [3c+:3]  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module rgb_pwm_test_top #(
  parameter int CHANNELS   = 1,
  parameter int FRAME_BITS = 3,
  parameter int PWM_BITS   = 4,
  parameter int STEP_DIV   = 8
) (
  input  logic                    clk,
  input  logic                    async_rst,
  input  logic                    clk_en,
  input  logic [FRAME_BITS-1:0]   count_lower,
  input  logic                    invert_led_state,
  input  logic [1:0]              mode,
  output logic [FRAME_BITS-1:0]   frame_out,
  output logic                    step_strobe,
  output logic [6:0]              digit,
  output logic [3*CHANNELS-1:0]   rgb_pwm
);

  localparam int                  DIV_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE    = DIV_W'(1);
  localparam logic [PWM_BITS:0]   DUTY_FULL  = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS:0]   DUTY_ONE   = (PWM_BITS + 1)'(1);
  localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);
  localparam logic [FRAME_BITS-1:0] FRAME_ONE = FRAME_BITS'(1);

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Segment chase: a..f walk the outer ring, g lights on 6, blank on 7.
  function automatic logic [6:0] seg_anim(input logic [2:0] f);
    logic [6:0] s;
    case (f)
      3'd0:    s = 7'b000_0001;
      3'd1:    s = 7'b000_0010;
      3'd2:    s = 7'b000_0100;
      3'd3:    s = 7'b000_1000;
      3'd4:    s = 7'b001_0000;
      3'd5:    s = 7'b010_0000;
      3'd6:    s = 7'b100_0000;
      default: s = 7'b000_0000;
    endcase
    return s;
  endfunction

  logic [FRAME_BITS-1:0] frame_q,       frame_d;
  logic                  invert_q,      invert_d;
  logic [1:0]            mode_q,        mode_d;
  logic [DIV_W-1:0]      div_cnt_q,     div_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q,     pwm_cnt_d;
  logic [PWM_BITS:0]     duty_q,        duty_d;
  dir_t                  dir_q,         dir_d;
  logic                  step_strobe_q, step_strobe_d;
  logic [6:0]            digit_q,       digit_d;
  logic [3*CHANNELS-1:0] rgb_q,         rgb_d;

  logic                  w_step;
  logic                  w_pwm_on;
  logic [PWM_BITS:0]     w_duty_next;
  logic [FRAME_BITS-1:0] w_col;

  always_comb begin
    frame_d       = frame_q;
    invert_d      = invert_q;
    mode_d        = mode_q;
    div_cnt_d     = div_cnt_q;
    pwm_cnt_d     = pwm_cnt_q;
    duty_d        = duty_q;
    dir_d         = dir_q;
    digit_d       = digit_q;
    step_strobe_d = 1'b0;
    w_duty_next   = duty_q;
    w_col         = '0;

    // mode_q is the mode in force for this edge; a new mode input takes
    // effect from the following clk_en, so a change and a step on the same
    // edge are resolved with the old mode.
    w_step   = (mode_q == MODE_AUTO) && (div_cnt_q == DIV_LAST);
    w_pwm_on = ({1'b0, pwm_cnt_q} < duty_q);

    rgb_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_col             = frame_q + FRAME_BITS'(c);
      rgb_d[3*c +: 3]   = w_pwm_on ? w_col[2:0] : 3'b000;
    end

    if (clk_en) begin
      invert_d      = invert_q ^ invert_led_state;
      mode_d        = mode;
      pwm_cnt_d     = pwm_cnt_q + PWM_ONE;
      digit_d       = seg_anim(frame_q[2:0]);
      step_strobe_d = w_step;

      case (mode_q)
        MODE_DIRECT, MODE_BREATHE: frame_d = invert_q ? ~count_lower : count_lower;
        MODE_AUTO: begin
          if (w_step) begin
            frame_d = invert_q ? (frame_q - FRAME_ONE) : (frame_q + FRAME_ONE);
          end
        end
        default: frame_d = frame_q;
      endcase

      // Cleared outside auto mode so entry always waits a full STEP_DIV.
      if ((mode_q == MODE_AUTO) && !w_step) begin
        div_cnt_d = div_cnt_q + DIV_ONE;
      end else begin
        div_cnt_d = '0;
      end

      // Duty is full outside breathe; entering breathe restarts the ramp at
      // zero, and each PWM period wrap moves one step along the triangle.
      if (mode == MODE_BREATHE) begin
        if (mode_q == MODE_BREATHE) begin
          if (pwm_cnt_q == PWM_MAX) begin
            w_duty_next = (dir_q == DIR_UP) ? (duty_q + DUTY_ONE) : (duty_q - DUTY_ONE);
            duty_d      = w_duty_next;
            if (w_duty_next == DUTY_FULL) begin
              dir_d = DIR_DOWN;
            end else if (w_duty_next == '0) begin
              dir_d = DIR_UP;
            end
          end
        end else begin
          duty_d = '0;
          dir_d  = DIR_UP;
        end
      end else begin
        duty_d = DUTY_FULL;
        dir_d  = DIR_UP;
      end
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      frame_q       <= '0;
      invert_q      <= 1'b0;
      mode_q        <= MODE_DIRECT;
      div_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      duty_q        <= DUTY_FULL;
      dir_q         <= DIR_UP;
      step_strobe_q <= 1'b0;
      digit_q       <= '0;
      rgb_q         <= '0;
    end else begin
      frame_q       <= frame_d;
      invert_q      <= invert_d;
      mode_q        <= mode_d;
      div_cnt_q     <= div_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_q        <= duty_d;
      dir_q         <= dir_d;
      step_strobe_q <= step_strobe_d;
      digit_q       <= digit_d;
      rgb_q         <= rgb_d;
    end
  end

  // MODE_HOLD is handled by the default branches above (everything holds).
  logic w_unused_hold;
  assign w_unused_hold = (MODE_HOLD == 2'b11);

  assign frame_out   = frame_q;
  assign step_strobe = step_strobe_q;
  assign digit       = digit_q;
  assign rgb_pwm     = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_test_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rgb_pwm_test_top                                        |
// | Description : Self-checking bench for rgb_pwm_test_top (3 channels),     |
// |               with a behavioural reference model of frame, invert,       |
// |               auto-step and breathe triangle.                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_rgb_pwm_test_top;

  localparam int CH = 3;
  localparam int FB = 3;
  localparam int PB = 4;
  localparam int SD = 8;

  logic          clk = 1'b0;
  logic          async_rst = 1'b0;
  logic          clk_en = 1'b0;
  logic [FB-1:0] cl = '0;
  logic          inv_in = 1'b0;
  logic [1:0]    mode_in = 2'b00;
  logic [FB-1:0] frame_out;
  logic          step_strobe;
  logic [6:0]    digit;
  logic [3*CH-1:0] rgb_pwm;

  int checks = 0;
  int errors = 0;

  rgb_pwm_test_top #(
    .CHANNELS(CH), .FRAME_BITS(FB), .PWM_BITS(PB), .STEP_DIV(SD)
  ) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .count_lower(cl),
    .invert_led_state(inv_in), .mode(mode_in), .frame_out(frame_out),
    .step_strobe(step_strobe), .digit(digit), .rgb_pwm(rgb_pwm)
  );

  always #5 clk = ~clk;

  // Reference model state (plain integers).
  int m_inv, m_frame, m_mode, m_div, m_pwm, m_k;
  logic [3*CH-1:0] m_rgb;
  logic [6:0] m_digit;
  logic m_strobe;

  logic [6:0] anim_tab [8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h00};

  // Duty in period k of a breathe run: 0,1,..,16,15,..,1,0,1,...
  function automatic int tri_duty(input int k);
    int r;
    r = k % 32;
    return (r <= 16) ? r : 32 - r;
  endfunction

  function automatic int model_duty();
    return (m_mode == 2) ? tri_duty(m_k) : 16;
  endfunction

  function automatic logic [3*CH-1:0] model_rgb();
    logic [3*CH-1:0] r;
    logic [2:0] col;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      col = 3'((m_frame + c) % 8);
      r[3*c +: 3] = (m_pwm < model_duty()) ? col : 3'b000;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_inv = 0; m_frame = 0; m_mode = 0; m_div = 0; m_pwm = 0; m_k = 0;
    m_rgb = '0; m_digit = '0; m_strobe = 1'b0;
  endtask

  // Advance one clock: model next state from current inputs, then DUT edge.
  task automatic tick();
    int n_inv, n_frame, n_mode, n_div, n_pwm, n_k;
    logic [3*CH-1:0] n_rgb;
    logic [6:0] n_digit;
    logic n_strobe, step;
    logic [2:0] ncl;
    n_inv = m_inv; n_frame = m_frame; n_mode = m_mode; n_div = m_div;
    n_pwm = m_pwm; n_k = m_k; n_digit = m_digit; n_strobe = 1'b0;
    n_rgb = model_rgb();
    ncl = ~cl;
    if (clk_en) begin
      step = (m_mode == 1) && (m_div == SD - 1);
      if (m_mode == 0 || m_mode == 2) n_frame = m_inv ? int'(ncl) : int'(cl);
      else if (m_mode == 1 && step) n_frame = m_inv ? (m_frame + 7) % 8 : (m_frame + 1) % 8;
      n_div = (m_mode == 1) ? (m_div + 1) % SD : 0;
      if (mode_in == 2) n_k = (m_mode == 2) ? m_k + ((m_pwm == 15) ? 1 : 0) : 0;
      n_pwm = (m_pwm + 1) % 16;
      n_inv = m_inv ^ int'(inv_in);
      n_mode = int'(mode_in);
      n_digit = anim_tab[m_frame];
      n_strobe = step;
    end
    @(posedge clk);
    #1;
    m_inv = n_inv; m_frame = n_frame; m_mode = n_mode; m_div = n_div;
    m_pwm = n_pwm; m_k = n_k; m_rgb = n_rgb; m_digit = n_digit; m_strobe = n_strobe;
  endtask

  task automatic test_reset();
    #1 async_rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (frame_out !== '0) begin errors++; $display("FAIL reset_frame: got %0d want 0", frame_out); end
    checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b want 0", step_strobe); end
    checks++; if (digit !== 7'h00) begin errors++; $display("FAIL reset_digit: got %h want 00", digit); end
    checks++; if (rgb_pwm !== '0) begin errors++; $display("FAIL reset_rgb: got %b want 0", rgb_pwm); end
    async_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_direct();
    mode_in = 2'b00; cl = 3'b101; clk_en = 1'b1; inv_in = 1'b0;
    tick();
    checks++; if (frame_out !== 3'd5) begin errors++; $display("FAIL direct_frame: got %0d want 5", frame_out); end
    tick();
    checks++; if (rgb_pwm !== 9'b111_110_101) begin errors++; $display("FAIL direct_rgb: got %b want 111110101", rgb_pwm); end
    checks++; if (digit !== 7'h20) begin errors++; $display("FAIL direct_digit: got %h want 20", digit); end
    cl = 3'b110;
    tick(); tick();
    checks++; if (rgb_pwm !== 9'b000_111_110) begin errors++; $display("FAIL channels_wrap: got %b want 000111110", rgb_pwm); end
    checks++; if (rgb_pwm !== m_rgb) begin errors++; $display("FAIL channels_model: got %b want %b", rgb_pwm, m_rgb); end
  endtask

  task automatic test_invert();
    cl = 3'b001; inv_in = 1'b1;
    tick(); inv_in = 1'b0;
    checks++; if (frame_out !== 3'b001) begin errors++; $display("FAIL invert_same_edge: got %b want 001", frame_out); end
    tick();
    checks++; if (frame_out !== 3'b110) begin errors++; $display("FAIL invert_on: got %b want 110", frame_out); end
    inv_in = 1'b1;
    tick(); inv_in = 1'b0;
    checks++; if (frame_out !== 3'b110) begin errors++; $display("FAIL invert_hold: got %b want 110", frame_out); end
    tick();
    checks++; if (frame_out !== 3'b001) begin errors++; $display("FAIL invert_off: got %b want 001", frame_out); end
  endtask

  task automatic test_auto_step();
    cl = 3'd7; tick();
    mode_in = 2'b01; tick();
    checks++; if (frame_out !== 3'd7) begin errors++; $display("FAIL auto_entry: got %0d want 7", frame_out); end
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (frame_out !== 3'd7 || step_strobe !== 1'b0) begin
        errors++; $display("FAIL auto_wait%0d: got frame %0d strobe %0b want 7/0", i, frame_out, step_strobe);
      end
    end
    tick();
    checks++; if (frame_out !== 3'd0 || step_strobe !== 1'b1) begin
      errors++; $display("FAIL auto_wrap_up: got frame %0d strobe %0b want 0/1", frame_out, step_strobe); end
    clk_en = 1'b0; tick();
    checks++; if (frame_out !== 3'd0 || step_strobe !== 1'b0) begin
      errors++; $display("FAIL auto_strobe_pulse: got frame %0d strobe %0b want 0/0", frame_out, step_strobe); end
    clk_en = 1'b1; inv_in = 1'b1; tick(); inv_in = 1'b0;
    repeat (7) tick();
    checks++; if (frame_out !== 3'd7 || step_strobe !== 1'b1) begin
      errors++; $display("FAIL auto_wrap_down: got frame %0d strobe %0b want 7/1", frame_out, step_strobe); end
    inv_in = 1'b1; tick(); inv_in = 1'b0;
  endtask

  task automatic test_breathe();
    int cnt, k0, guard;
    mode_in = 2'b00; cl = 3'd1; tick(); tick();
    mode_in = 2'b10; tick();
    guard = 0;
    while (m_pwm != 0 && guard < 20) begin tick(); guard++; end
    checks++; if (m_pwm != 0) begin errors++; $display("FAIL breathe_align: got pwm %0d want 0", m_pwm); end
    for (int p = 0; p < 36; p++) begin
      k0 = m_k; cnt = 0;
      repeat (16) begin
        tick();
        if (rgb_pwm[2:0] !== 3'b000) cnt++;
      end
      checks++;
      if (cnt != tri_duty(k0)) begin
        errors++; $display("FAIL breathe_period%0d: got %0d/16 want %0d/16", k0, cnt, tri_duty(k0));
      end
    end
    mode_in = 2'b00; tick();
    cnt = 0;
    repeat (16) begin tick(); if (rgb_pwm[2:0] === 3'b001) cnt++; end
    checks++; if (cnt != 16) begin errors++; $display("FAIL breathe_leave: got %0d/16 want 16/16", cnt); end
  endtask

  task automatic check_all_vs_model(input int n);
    checks++;
    if (frame_out !== 3'(m_frame) || step_strobe !== m_strobe || digit !== m_digit || rgb_pwm !== m_rgb) begin
      errors++;
      $display("FAIL random_%0d: got f=%0d s=%0b d=%h rgb=%b want f=%0d s=%0b d=%h rgb=%b",
               n, frame_out, step_strobe, digit, rgb_pwm, m_frame, m_strobe, m_digit, m_rgb);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clk_en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 39) == 0) mode_in = 2'($urandom_range(0, 3));
      cl = 3'($urandom);
      inv_in = ($urandom_range(0, 9) == 0);
      tick();
      check_all_vs_model(i);
    end
    inv_in = 1'b0;
  endtask

  task automatic test_async_reset();
    clk_en = 1'b1; mode_in = 2'b10; cl = 3'd3;
    repeat (40) tick();
    #3 async_rst = 1'b1;
    #1;
    checks++; if (frame_out !== '0) begin errors++; $display("FAIL arst_frame: got %0d want 0", frame_out); end
    checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL arst_strobe: got %0b want 0", step_strobe); end
    checks++; if (digit !== 7'h00) begin errors++; $display("FAIL arst_digit: got %h want 00", digit); end
    checks++; if (rgb_pwm !== '0) begin errors++; $display("FAIL arst_rgb: got %b want 0", rgb_pwm); end
    @(posedge clk); #1;
    async_rst = 1'b0;
    model_reset();
    mode_in = 2'b00;
    for (int i = 0; i < 60; i++) begin
      clk_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) mode_in = 2'($urandom_range(0, 3));
      cl = 3'($urandom);
      tick();
      check_all_vs_model(1000 + i);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_direct();
    test_invert();
    test_auto_step();
    test_breathe();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
